flash_playback_seq: RTL

Playback sequencer for the flash-resident audio stream. Walks a word-addressed flash region one byte per sample tick, forward or reverse. Issues one 32-bit read per word over a req/ack handshake, buffers the word and serves its bytes to the decoder front end. Handles pause, restart, end-of-region wrap and underrun reporting.

---
 rtl/flash_playback_seq_if.sv | 12 +
 rtl/flash_playback_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/flash_playback_seq_if.sv
// Flash read port: one 32-bit word per request, req held until a one-cycle ack.
interface flash_playback_seq_if #(
    parameter int unsigned ADDR_W = 23
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/flash_playback_seq.sv
// Playback sequencer: streams a flash word region one byte per tick, forward or reverse.
// Define FLASH_SEQ_UNDERRUN_CNT_EN to build the saturating underrun counter.
module flash_playback_seq #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick_i,
    input  logic                 play_i,
    input  logic                 reverse_i,
    input  logic                 restart_i,
    flash_playback_seq_if.master flash,
    output logic [7:0]           byte_out_o,
    output logic                 byte_valid_o,
    output logic                 underrun_o,
    output logic                 wrapped_o,
    output logic [15:0]          underrun_count_o
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       buf_q, buf_d;
    logic              discard_q, discard_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              underrun_q, underrun_d;
    logic              wrapped_q, wrapped_d;
    logic              tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wptr_q       <= START_ADDR;
            addr_q       <= START_ADDR;
            bidx_q       <= '0;
            buf_q        <= '0;
            discard_q    <= 1'b0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            addr_q       <= addr_d;
            bidx_q       <= bidx_d;
            buf_q        <= buf_d;
            discard_q    <= discard_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            underrun_q   <= underrun_d;
            wrapped_q    <= wrapped_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        addr_d       = addr_q;
        bidx_d       = bidx_q;
        buf_d        = buf_q;
        discard_d    = discard_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        underrun_d   = 1'b0;
        wrapped_d    = 1'b0;
        tick         = sample_tick_i && play_i && !restart_i;

        unique case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                addr_d     = wptr_q;
                underrun_d = tick;
            end
            S_FETCH: begin
                underrun_d = tick;
                if (flash.ack) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        addr_d    = wptr_q;
                    end else begin
                        buf_d   = flash.rdata;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (tick) begin
                    byte_d       = buf_q[{bidx_q, 3'b000} +: 8];
                    byte_valid_d = 1'b1;
                    if (!reverse_i) begin
                        bidx_d = bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            state_d = S_FETCH;
                            if (wptr_q == END_ADDR) begin
                                wptr_d    = START_ADDR;
                                wrapped_d = 1'b1;
                            end else begin
                                wptr_d = wptr_q + ADDR_W'(1);
                            end
                            addr_d = wptr_d;
                        end
                    end else begin
                        bidx_d = bidx_q - 2'd1;
                        if (bidx_q == 2'd0) begin
                            state_d = S_FETCH;
                            if (wptr_q == START_ADDR) begin
                                wptr_d    = END_ADDR;
                                wrapped_d = 1'b1;
                            end else begin
                                wptr_d = wptr_q - ADDR_W'(1);
                            end
                            addr_d = wptr_d;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An in-flight request keeps its address; its data is dropped via discard.
        if (restart_i) begin
            wptr_d  = reverse_i ? END_ADDR : START_ADDR;
            bidx_d  = reverse_i ? 2'd3 : 2'd0;
            state_d = S_FETCH;
            if (state_q == S_FETCH && !flash.ack) begin
                discard_d = 1'b1;
            end else begin
                discard_d = 1'b0;
                addr_d    = wptr_d;
            end
        end
    end

    assign flash.req    = (state_q == S_FETCH);
    assign flash.addr   = addr_q;
    assign byte_out_o   = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign underrun_o   = underrun_q;
    assign wrapped_o    = wrapped_q;

`ifdef FLASH_SEQ_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (underrun_d && ucnt_q != 16'hFFFF) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count_o = ucnt_q;
`else
    assign underrun_count_o = '0;
`endif
endmodule
